muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_abs.sv | 12 +
 rtl/muldiv_unit.sv | 156 +++++++++++++++
 tb/tb_muldiv_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op/state encodings for the multiply/divide unit
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    // Multi-cycle ops occupy the low half of the encoding space.
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op <= 3'd3);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_abs.sv
// rtl/muldiv_abs.sv - combinational conditional two's-complement negate
module muldiv_abs #(
    parameter int W = 32
) (
    input  logic         i_neg,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + {{(W-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO (option: MULDIV_EARLY_OUT_EN)
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] hi,
    output logic [n-1:0] lo
);

    localparam int CW = $clog2(n) + 1;

    state_e          r_state;
    state_e          w_next;
    logic [CW-1:0]   r_cnt;
    logic [2*n-1:0]  r_acc;     // mul: running product; div: {remainder, quotient/dividend}
    logic [2*n-1:0]  r_mc;      // multiplicand, shifted left one place per step
    logic [n-1:0]    r_mb;      // mul: remaining multiplier bits; div: divisor
    logic            r_is_div;
    logic            r_neg_q;   // product / quotient must be negated
    logic            r_neg_r;   // remainder must be negated
    logic            r_dz;      // divide by zero: quotient forced to all ones
    logic [n-1:0]    r_hi;
    logic [n-1:0]    r_lo;
    logic            r_done;

    logic            w_signed;
    logic [n-1:0]    w_a_mag;
    logic [n-1:0]    w_b_mag;
    logic [n:0]      w_rem_sh;
    logic [n:0]      w_diff;
    logic [2*n-1:0]  w_div_acc;
    logic [2*n-1:0]  w_mul_acc;
    logic [2*n-1:0]  w_prod;
    logic [n-1:0]    w_quo;
    logic [n-1:0]    w_rem;
    logic            w_early;

    assign w_signed = is_signed_op(op);

    muldiv_abs #(.W(n)) u_abs_a (.i_neg(w_signed & a[n-1]), .i_val(a), .o_val(w_a_mag));
    muldiv_abs #(.W(n)) u_abs_b (.i_neg(w_signed & b[n-1]), .i_val(b), .o_val(w_b_mag));

    // Restoring divide step: shift in next dividend bit, subtract if it fits.
    assign w_rem_sh  = {r_acc[2*n-1:n], r_acc[n-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_mb};
    assign w_div_acc = w_diff[n] ? {w_rem_sh[n-1:0], r_acc[n-2:0], 1'b0}
                                 : {w_diff[n-1:0],   r_acc[n-2:0], 1'b1};

    // Multiply step: the multiplicand is already aligned to the current bit weight,
    // so stopping early leaves a complete product.
    assign w_mul_acc = r_mb[0] ? (r_acc + r_mc) : r_acc;

    muldiv_abs #(.W(2*n)) u_fix_prod (.i_neg(r_neg_q), .i_val(r_acc),          .o_val(w_prod));
    muldiv_abs #(.W(n))   u_fix_quo  (.i_neg(r_neg_q), .i_val(r_acc[n-1:0]),   .o_val(w_quo));
    muldiv_abs #(.W(n))   u_fix_rem  (.i_neg(r_neg_r), .i_val(r_acc[2*n-1:n]), .o_val(w_rem));

`ifdef MULDIV_EARLY_OUT_EN
    assign w_early = !r_is_div && (r_mb[n-1:1] == '0);
`else
    assign w_early = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start && is_muldiv(op)) w_next = CALC;
            CALC:    if ((r_cnt == CW'(1)) || w_early) w_next = FIX;
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, sign fix and HI/LO writeback.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mc     <= '0;
            r_mb     <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (op == OP_MTHI) begin
                            r_hi   <= a;
                            r_done <= 1'b1;
                        end else if (op == OP_MTLO) begin
                            r_lo   <= a;
                            r_done <= 1'b1;
                        end else if (is_muldiv(op)) begin
                            r_is_div <= op[1];
                            r_neg_q  <= w_signed & (a[n-1] ^ b[n-1]);
                            r_neg_r  <= w_signed & a[n-1];
                            r_dz     <= (b == '0);
                            r_cnt    <= CW'(n);
                            r_mb     <= w_b_mag;
                            r_mc     <= {{n{1'b0}}, w_a_mag};
                            r_acc    <= op[1] ? {{n{1'b0}}, w_a_mag} : '0;
                        end
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_is_div) begin
                        r_acc <= w_div_acc;
                    end else begin
                        r_acc <= w_mul_acc;
                        r_mc  <= r_mc << 1;
                        r_mb  <= r_mb >> 1;
                    end
                end
                FIX: begin
                    r_done <= 1'b1;
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= r_dz ? '1 : w_quo;
                    end else begin
                        r_hi <= w_prod[2*n-1:n];
                        r_lo <= w_prod[n-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    muldiv_unit #(.n(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Architectural result {hi, lo} computed with plain integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                          input logic [63:0] prev);
        int q, r;
        case (o)
            3'd0: return longint'($signed(x)) * longint'($signed(y));
            3'd1: return {32'h0, x} * {32'h0, y};
            3'd2: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = int'(x) / int'(y);
                r = int'(x) % int'(y);
                return {r, q};
            end
            3'd3: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            3'd4: return {x, prev[31:0]};
            3'd5: return {prev[63:32], x};
            default: return prev;
        endcase
    endfunction

    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] e;
        int bc;
        e = model(o, x, y, {exp_hi, exp_lo});
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        if (o <= 3'd3) begin
            bc = 0;
            while (busy === 1'b1 && bc < 100) begin
                bc++;
                @(negedge clk);
            end
`ifndef MULDIV_EARLY_OUT_EN
            check($sformatf("latency op%0d", o), 64'(bc), 64'd33);
`else
            if (o[1]) check($sformatf("latency op%0d", o), 64'(bc), 64'd33);
            else      check($sformatf("latency_max op%0d", o), 64'(bc >= 1 && bc <= 33), 64'd1);
`endif
            check($sformatf("done op%0d", o), 64'(done), 64'd1);
        end else if (o <= 3'd5) begin
            check($sformatf("mt_busy op%0d", o), 64'(busy), 64'd0);
            check($sformatf("mt_done op%0d", o), 64'(done), 64'd1);
        end else begin
            check("undef_busy", 64'(busy), 64'd0);
            check("undef_done", 64'(done), 64'd0);
        end
        {exp_hi, exp_lo} = e;
        check($sformatf("hi op%0d a=%h b=%h", o, x, y), 64'(hi), 64'(exp_hi));
        check($sformatf("lo op%0d a=%h b=%h", o, x, y), 64'(lo), 64'(exp_lo));
        @(negedge clk);
        check($sformatf("done_pulse op%0d", o), 64'(done), 64'd0);
    endtask

    initial begin
        int bc;
        logic [2:0]  ro;
        logic [31:0] rx, ry;
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi",   64'(hi),   64'd0);
        check("rst_lo",   64'(lo),   64'd0);
        rst_n = 1'b1;

        do_op(3'd0, 32'hFFFF_FFFD, 32'd7);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(3'd3, 32'd7, 32'd0);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd0);
        do_op(3'd4, 32'h0000_1234, 32'd0);
        do_op(3'd5, 32'hCAFE_F00D, 32'd0);
        do_op(3'd6, 32'h1111_1111, 32'h2222_2222);
        do_op(3'd0, 32'h1234_5678, 32'd0);
        do_op(3'd1, 32'hDEAD_BEEF, 32'd1);

        // start raised while busy must not disturb the running divide
        @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd7;
        @(negedge clk);
        op = 3'd0; a = 32'd5; b = 32'd5;
        bc = 0;
        while (busy === 1'b1 && bc < 100) begin
            bc++;
            @(negedge clk);
            start = 1'b0;
        end
        check("busy_ignore_latency", 64'(bc), 64'd33);
        check("busy_ignore_done", 64'(done), 64'd1);
        check("busy_ignore_hi", 64'(hi), 64'd6);
        check("busy_ignore_lo", 64'(lo), 64'd142);
        exp_hi = 32'd6; exp_lo = 32'd142;
        @(negedge clk);

        // reset in the middle of an operation
        start = 1'b1; op = 3'd3; a = 32'd99; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_hi",   64'(hi),   64'd0);
        check("midrst_lo",   64'(lo),   64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        exp_hi = '0; exp_lo = '0;
        repeat (3) begin
            @(negedge clk);
            check("midrst_nodone", 64'(done), 64'd0);
        end

        for (int i = 0; i < 30; i++) begin
            ro = 3'($urandom_range(0, 5));
            rx = $urandom;
            case ($urandom_range(0, 5))
                0: ry = 32'h0;
                1: ry = 32'($urandom_range(0, 3));
                2: ry = 32'hFFFF_FFFF;
                3: begin ry = $urandom; rx = 32'h8000_0000; end
                default: ry = $urandom;
            endcase
            do_op(ro, rx, ry);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
